// File: rtl/telemetry_tx_seq.sv
// Frames a telemetry snapshot as HDR0,HDR1,payload(MSB first),~sum for a byte UART; one trmt per byte.
// Request->trmt 2 cycles, tx_done edge->next trmt 2 cycles; waits on tx_done rising edge, drops excess requests.
module telemetry_tx_seq #(
  parameter int          NUM_BYTES = 6,
  parameter int          PERIOD    = 50000,
  parameter logic [7:0]  HDR0      = 8'hAA,
  parameter logic [7:0]  HDR1      = 8'h55
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   force_send,
  input  logic [8*NUM_BYTES-1:0] data_in,
  input  logic                   tx_done,
  output logic                   trmt,
  output logic [7:0]             tx_data,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   frame_drop
);

  localparam int              CW   = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam int              IW   = 5;
  localparam logic [IW-1:0]   LAST = IW'(NUM_BYTES + 2);
  localparam logic [CW-1:0]   WRAP = CW'(PERIOD - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, FIN} state_t;

  state_t                 state;
  state_t                 state_next;
  logic [CW-1:0]          period_cnt;
  logic                   pending;
  logic [IW-1:0]          byte_idx;
  logic [7:0]             csum;
  logic [8*NUM_BYTES-1:0] snap;
  logic                   tx_done_q;

  logic                   tick;
  logic                   req;
  logic                   accept;
  logic                   done_evt;
  logic [IW-1:0]          pay_pos;
  logic [8*NUM_BYTES-1:0] pay_shift;
  logic [7:0]             cur_byte;
  logic                   is_payload;

  assign tick     = en && (period_cnt == WRAP);
  assign req      = tick || force_send;
  assign accept   = (state == IDLE) && pending;
  // tx_done is a sticky level in the UART, so only its rising edge means "byte finished".
  assign done_evt = tx_done && !tx_done_q;

  // Payload index 2 maps to the most-significant byte of the snapshot.
  assign pay_pos    = LAST - byte_idx - IW'(1);
  assign pay_shift  = snap >> {pay_pos, 3'b000};
  assign is_payload = (byte_idx >= IW'(2)) && (byte_idx < LAST);

  always_comb begin
    cur_byte = pay_shift[7:0];
    if (byte_idx == IW'(0)) begin
      cur_byte = HDR0;
    end else if (byte_idx == IW'(1)) begin
      cur_byte = HDR1;
    end else if (byte_idx == LAST) begin
      cur_byte = ~csum;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (pending) state_next = SEND;
      SEND: state_next = WAIT;
      WAIT: begin
        if (done_evt) begin
          state_next = (byte_idx == LAST) ? FIN : SEND;
        end
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      period_cnt <= '0;
      pending    <= 1'b0;
      byte_idx   <= '0;
      csum       <= 8'h00;
      snap       <= '0;
      tx_done_q  <= 1'b0;
      trmt       <= 1'b0;
      tx_data    <= 8'h00;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_drop <= 1'b0;
    end else begin
      state      <= state_next;
      tx_done_q  <= tx_done;
      trmt       <= (state == SEND);
      busy       <= (state_next != IDLE);
      frame_done <= (state_next == FIN);

      if (!en || tick) begin
        period_cnt <= '0;
      end else begin
        period_cnt <= period_cnt + CW'(1);
      end

      // A simultaneous tick and force_send is a single request; a request landing on
      // the same edge that IDLE consumes the pending one is kept, not dropped.
      frame_drop <= req && pending && !accept;
      if (req) begin
        pending <= 1'b1;
      end else if (accept) begin
        pending <= 1'b0;
      end

      if (accept) begin
        snap     <= data_in;
        byte_idx <= '0;
        csum     <= 8'h00;
      end

      if (state == SEND) begin
        tx_data <= cur_byte;
        if (is_payload) begin
          csum <= csum + cur_byte;
        end
      end

      if ((state == WAIT) && done_evt && (byte_idx != LAST)) begin
        byte_idx <= byte_idx + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_telemetry_tx_seq.sv
// Directed bench for telemetry_tx_seq with NUM_BYTES=2, PERIOD=100 and a behavioural UART model.
module tb_telemetry_tx_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        force_send = 1'b0;
  logic [15:0] data_in = 16'h1234;
  logic        tx_done = 1'b0;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        busy;
  logic        frame_done;
  logic        frame_drop;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int uart_delay = 3;
  bit uart_auto = 1'b1;
  bit manual_td = 1'b0;
  int ucnt = 0;

  int trmt_cnt = 0;
  int done_cnt = 0;
  int drop_cnt = 0;
  bit busy_q = 1'b0;
  logic [7:0] byte_q[$];
  int trmt_t[$];
  int fin_t[$];
  int start_t[$];

  telemetry_tx_seq #(.NUM_BYTES(2), .PERIOD(100), .HDR0(8'hAA), .HDR1(8'h55)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .force_send (force_send),
    .data_in    (data_in),
    .tx_done    (tx_done),
    .trmt       (trmt),
    .tx_data    (tx_data),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_drop (frame_drop)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Monitor plus UART model: tx_done drops on trmt and rises uart_delay cycles later.
  always @(negedge clk) begin
    if (trmt) begin
      trmt_cnt++;
      byte_q.push_back(tx_data);
      trmt_t.push_back(cyc);
    end
    if (frame_done) begin
      done_cnt++;
      fin_t.push_back(cyc);
    end
    if (frame_drop) drop_cnt++;
    if (busy && !busy_q) start_t.push_back(cyc);
    busy_q = busy;
    if (uart_auto) begin
      if (trmt) begin
        tx_done = 1'b0;
        ucnt = uart_delay;
      end else if (ucnt > 0) begin
        ucnt--;
        if (ucnt == 0) tx_done = 1'b1;
      end
    end else begin
      tx_done = manual_td;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_trmt(input int n, input int budget, input string tag);
    int k = 0;
    while (trmt_cnt < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(trmt_cnt >= n), 32'd1);
  endtask

  task automatic wait_done(input int n, input int budget, input string tag);
    int k = 0;
    while (done_cnt < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(done_cnt >= n), 32'd1);
  endtask

  task automatic pulse_force();
    @(negedge clk);
    force_send = 1'b1;
    @(negedge clk);
    force_send = 1'b0;
  endtask

  task automatic td_edge();
    @(negedge clk);
    manual_td = 1'b0;
    @(negedge clk);
    manual_td = 1'b1;
  endtask

  initial begin
    int b;
    int f;
    int e;
    int t0;
    int s0;
    int d0;
    int k;

    repeat (3) @(negedge clk);
    chk("rst_trmt", 32'(trmt), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'h00);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_frame_drop", 32'(frame_drop), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Forced frame, 20-cycle UART, data_in changes after the first byte goes out.
    uart_delay = 20;
    b = trmt_cnt;
    pulse_force();
    f = cyc;
    wait_trmt(b + 1, 20, "t1_first_trmt_seen");
    data_in = 16'hFFFF;
    wait_done(1, 400, "t1_frame_done_seen");
    repeat (5) @(negedge clk);
    chk("t1_trmt_count", 32'(trmt_cnt - b), 32'd5);
    chk("t1_byte0", 32'(byte_q[b]), 32'hAA);
    chk("t1_byte1", 32'(byte_q[b+1]), 32'h55);
    chk("t1_byte2", 32'(byte_q[b+2]), 32'h12);
    chk("t1_byte3", 32'(byte_q[b+3]), 32'h34);
    chk("t1_csum", 32'(byte_q[b+4]), 32'hB9);
    chk("t1_req_to_trmt", 32'(trmt_t[b] - f), 32'd2);
    chk("t1_byte_gap", 32'(trmt_t[b+1] - trmt_t[b]), 32'd22);
    chk("t1_done_count", 32'(done_cnt), 32'd1);
    chk("t1_busy_after", 32'(busy), 32'd0);
    chk("t1_no_drop", 32'(drop_cnt), 32'd0);

    // Sticky tx_done: only rising edges advance the frame; then reset in WAIT on byte 3.
    data_in = 16'h1234;
    manual_td = 1'b0;
    uart_auto = 1'b0;
    repeat (2) @(negedge clk);
    b = trmt_cnt;
    pulse_force();
    wait_trmt(b + 1, 10, "t2_hdr0_seen");
    @(negedge clk);
    manual_td = 1'b1;
    wait_trmt(b + 2, 10, "t2_hdr1_seen");
    repeat (30) @(negedge clk);
    chk("t2_sticky_no_trmt", 32'(trmt_cnt - b), 32'd2);
    chk("t2_sticky_busy", 32'(busy), 32'd1);
    td_edge();
    wait_trmt(b + 3, 10, "t2_byte2_seen");
    td_edge();
    wait_trmt(b + 4, 10, "t2_byte3_seen");
    chk("t2_byte2", 32'(byte_q[b+2]), 32'h12);
    chk("t2_byte3", 32'(byte_q[b+3]), 32'h34);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t2_rst_trmt", 32'(trmt), 32'd0);
    chk("t2_rst_busy", 32'(busy), 32'd0);
    chk("t2_rst_tx_data", 32'(tx_data), 32'h00);
    td_edge();
    repeat (10) @(negedge clk);
    chk("t2_idle_edge_no_trmt", 32'(trmt_cnt - b), 32'd4);
    chk("t2_idle_edge_busy", 32'(busy), 32'd0);

    uart_delay = 3;
    uart_auto = 1'b1;
    d0 = done_cnt;
    b = trmt_cnt;
    pulse_force();
    wait_done(d0 + 1, 200, "t2_restart_done_seen");
    repeat (3) @(negedge clk);
    chk("t2_restart_count", 32'(trmt_cnt - b), 32'd5);
    chk("t2_restart_hdr0", 32'(byte_q[b]), 32'hAA);
    chk("t2_restart_csum", 32'(byte_q[b+4]), 32'hB9);

    // Periodic frames with a fast UART: tick at the 100th edge sampling en, trmt 2 edges later.
    b = trmt_cnt;
    s0 = start_t.size();
    k = drop_cnt;
    @(negedge clk);
    en = 1'b1;
    e = cyc;
    wait_trmt(b + 1, 150, "t3_first_trmt_seen");
    chk("t3_first_latency", 32'(trmt_t[b] - (e + 1)), 32'd101);
    k = 0;
    while (start_t.size() < s0 + 3 && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("t3_three_frames", 32'(start_t.size() - s0), 32'd3);
    chk("t3_interval_a", 32'(start_t[s0+1] - start_t[s0]), 32'd100);
    chk("t3_interval_b", 32'(start_t[s0+2] - start_t[s0+1]), 32'd100);
    wait_done(done_cnt + 1, 100, "t3_third_done_seen");
    en = 1'b0;
    repeat (300) @(negedge clk);
    chk("t3_en_off_no_frames", 32'(start_t.size() - s0), 32'd3);
    chk("t3_no_drop", 32'(drop_cnt - k + k), 32'(drop_cnt));
    chk("t3_drop_total", 32'(drop_cnt), 32'd0);

    // Slow UART (62 cycles/byte): frame outlasts PERIOD, extra ticks are dropped.
    uart_delay = 60;
    d0 = done_cnt;
    s0 = start_t.size();
    t0 = fin_t.size();
    @(negedge clk);
    en = 1'b1;
    wait_done(d0 + 1, 600, "t4_first_done_seen");
    repeat (2) @(negedge clk);
    chk("t4_drops", 32'(drop_cnt), 32'd2);
    k = 0;
    while (start_t.size() < s0 + 2 && k < 20) begin
      @(negedge clk);
      k++;
    end
    en = 1'b0;
    chk("t4_second_start_seen", 32'(start_t.size() - s0), 32'd2);
    chk("t4_fin_to_start", 32'(start_t[s0+1] - fin_t[t0]), 32'd2);
    k = 0;
    while (busy && k < 600) begin
      @(negedge clk);
      k++;
    end
    chk("t4_drained", 32'(busy), 32'd0);
    chk("t4_done_count", 32'(done_cnt - d0), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
